// File: rtl/sort4_sched.sv
// sort4_sched: sequential bubble sorter for N packed 4-bit keys.
//
// One shared 4-bit magnitude comparator is time-multiplexed over the
// working array. The sort follows a fixed schedule of N*(N-1)/2 compare
// cycles (no early exit), then the result is presented with a one-cycle
// done pulse.
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     synchronous, active-high reset
//   start_i     sort request, sampled only while idle
//   data_in_i   N unsorted keys, key k = data_in_i[4k+3:4k]
//   busy_o      high while sorting and during the done cycle
//   done_o      one-cycle pulse, data_out_o/swap_cnt_o valid
//   data_out_o  sorted keys, same packing (key 0 smallest when DESCEND=0)
//   swap_cnt_o  swaps made by the last sort (inversion count)

module sort4_cmp4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       eq_o,
    output logic       lt_o,
    output logic       gt_o
);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);
    assign gt_o = (a_i >  b_i);
endmodule

module sort4_sched #(
    parameter int N       = 4,
    parameter bit DESCEND = 1'b0,
    localparam int SW     = $clog2(N*(N-1)/2 + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [4*N-1:0]  data_in_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4*N-1:0]  data_out_o,
    output logic [SW-1:0]   swap_cnt_o
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      work_q [N];
    logic [3:0]      work_d [N];
    logic [IW-1:0]   p_q, p_d, i_q, i_d;
    logic [SW-1:0]   swaps_q, swaps_d;
    logic [4*N-1:0]  data_out_q, data_out_d;
    logic [SW-1:0]   swap_cnt_q, swap_cnt_d;

    logic [IW-1:0]   i_nxt;
    logic [IW-1:0]   last_i;
    logic            cmp_eq, cmp_lt, cmp_gt;
    logic            do_swap;

    assign i_nxt  = i_q + IW'(1);
    // Pass p only needs to reach the pair ending at N-1-p; later pairs
    // already hold their final values.
    assign last_i = IW'(N-2) - p_q;

    sort4_cmp4 u_cmp (
        .a_i  (work_q[i_q]),
        .b_i  (work_q[i_nxt]),
        .eq_o (cmp_eq),
        .lt_o (cmp_lt),
        .gt_o (cmp_gt)
    );

    // Equal keys never swap, which keeps the sort stable.
    assign do_swap = !cmp_eq && (DESCEND ? cmp_lt : cmp_gt);

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        p_d        = p_q;
        i_d        = i_q;
        swaps_d    = swaps_q;
        data_out_d = data_out_q;
        swap_cnt_d = swap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < N; k++) begin
                        work_d[k] = data_in_i[4*k +: 4];
                    end
                    swaps_d = '0;
                    p_d     = '0;
                    i_d     = '0;
                    state_d = ST_SORT;
                end
            end
            ST_SORT: begin
                if (do_swap) begin
                    work_d[i_q]   = work_q[i_nxt];
                    work_d[i_nxt] = work_q[i_q];
                    swaps_d       = swaps_q + SW'(1);
                end
                if (i_q == last_i) begin
                    i_d = '0;
                    p_d = p_q + IW'(1);
                end else begin
                    i_d = i_nxt;
                end
                if (p_q == IW'(N-2)) begin
                    // Final compare: capture the post-swap array so the
                    // result is valid during the done cycle.
                    for (int k = 0; k < N; k++) begin
                        data_out_d[4*k +: 4] = work_d[k];
                    end
                    swap_cnt_d = swaps_d;
                    p_d        = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            for (int k = 0; k < N; k++) begin
                work_q[k] <= '0;
            end
            p_q        <= '0;
            i_q        <= '0;
            swaps_q    <= '0;
            data_out_q <= '0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            p_q        <= p_d;
            i_q        <= i_d;
            swaps_q    <= swaps_d;
            data_out_q <= data_out_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign data_out_o = data_out_q;
    assign swap_cnt_o = swap_cnt_q;

endmodule

// File: tb/tb_sort4_sched.sv
// Testbench for sort4_sched: three builds (N=4 ascending, N=4 descending,
// N=2 ascending) share one clock. Stimulus pushes reference results into
// per-build queues; a monitor pops and compares on every done pulse.

module tb_sort4_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        st0, st1, st2;
    logic [15:0] di0, di1;
    logic [7:0]  di2;
    logic        b0, b1, b2, d0, d1, d2;
    logic [15:0] do0, do1;
    logic [7:0]  do2;
    logic [2:0]  sc0, sc1;
    logic [0:0]  sc2;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] data;
        int          sw;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort4_sched #(.N(4), .DESCEND(1'b0)) u_asc (
        .clk_i(clk), .reset_i(reset), .start_i(st0), .data_in_i(di0),
        .busy_o(b0), .done_o(d0), .data_out_o(do0), .swap_cnt_o(sc0));

    sort4_sched #(.N(4), .DESCEND(1'b1)) u_desc (
        .clk_i(clk), .reset_i(reset), .start_i(st1), .data_in_i(di1),
        .busy_o(b1), .done_o(d1), .data_out_o(do1), .swap_cnt_o(sc1));

    sort4_sched #(.N(2), .DESCEND(1'b0)) u_n2 (
        .clk_i(clk), .reset_i(reset), .start_i(st2), .data_in_i(di2),
        .busy_o(b2), .done_o(d2), .data_out_o(do2), .swap_cnt_o(sc2));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: inversion count by pairwise counting, result by library sort.
    function automatic exp_t model(logic [15:0] data, int n, bit desc);
        exp_t r;
        int   v[$];
        int   cnt = 0;
        for (int k = 0; k < n; k++) v.push_back(int'(data[4*k +: 4]));
        for (int j = 0; j < n; j++)
            for (int k = j + 1; k < n; k++)
                if (desc ? (v[j] < v[k]) : (v[j] > v[k])) cnt++;
        if (desc) v.rsort(); else v.sort();
        r.data = '0;
        for (int k = 0; k < n; k++) r.data[4*k +: 4] = 4'(v[k]);
        r.sw  = cnt;
        r.acc = 0;
        return r;
    endfunction

    function automatic logic busy_of(int w);
        case (w)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    // Called at a negedge: the next posedge is the accepting edge.
    task automatic issue(int w, logic [15:0] data);
        exp_t e;
        e = model(data, (w == 2) ? 2 : 4, (w == 1));
        e.acc = cyc + 1;
        case (w)
            0: begin st0 = 1'b1; di0 = data;      q0.push_back(e); end
            1: begin st1 = 1'b1; di1 = data;      q1.push_back(e); end
            default: begin st2 = 1'b1; di2 = data[7:0]; q2.push_back(e); end
        endcase
    endtask

    // Drop start and scramble data_in so late changes are exercised.
    task automatic release_start();
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        di0 = 16'($urandom); di1 = 16'($urandom); di2 = 8'($urandom);
    endtask

    task automatic run(int w, logic [15:0] data);
        int nc = (w == 2) ? 1 : 6;
        int hi = 0;
        bit low_seen = 1'b0;
        @(negedge clk);
        issue(w, data);
        for (int c = 0; c < nc + 2; c++) begin
            @(negedge clk);
            if (c == 0) release_start();
            if (busy_of(w)) begin
                if (!low_seen) hi++;
            end else begin
                low_seen = 1'b1;
            end
        end
        chk($sformatf("busy_len%0d", w), hi, low_seen ? nc + 1 : -1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (d0) begin
            if (q0.size() == 0) chk("done_unexp0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("data0", do0, e.data);
                chk("swap0", sc0, e.sw);
                chk("lat0", cyc - e.acc, 6);
            end
        end
        if (d1) begin
            if (q1.size() == 0) chk("done_unexp1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("data1", do1, e.data);
                chk("swap1", sc1, e.sw);
                chk("lat1", cyc - e.acc, 6);
            end
        end
        if (d2) begin
            if (q2.size() == 0) chk("done_unexp2", 1, 0);
            else begin
                e = q2.pop_front();
                chk("data2", {8'h00, do2}, e.data);
                chk("swap2", sc2, e.sw);
                chk("lat2", cyc - e.acc, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset = 1'b1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        di0 = '0; di1 = '0; di2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", b0, 0);
        chk("rst_done", d0, 0);
        chk("rst_data", do0, 0);
        chk("rst_swap", sc0, 0);
        reset = 1'b0;

        // Directed cases
        run(0, 16'h0339);   // {9,3,3,0} -> {0,3,3,9}, 5 swaps
        run(0, 16'h4321);   // already sorted
        run(0, 16'h7777);   // all equal
        run(0, 16'h05AF);   // reverse -> 6 swaps
        run(1, 16'h4321);   // descending of {1,2,3,4}
        run(2, 16'h0025);   // N=2 {5,2}

        // Starts during SORT (cycle 3) and DONE (cycle 7) are ignored;
        // start in cycle 8 is accepted.
        @(negedge clk);
        issue(0, 16'h1C5A);
        e0 = cyc + 1;
        @(negedge clk); release_start();
        while (cyc < e0 + 2) @(negedge clk);
        st0 = 1'b1; di0 = 16'hFFFF;
        @(negedge clk); release_start();
        while (cyc < e0 + 6) @(negedge clk);
        st0 = 1'b1; di0 = 16'h0000;
        @(negedge clk);
        release_start();
        issue(0, 16'h8E21);
        @(negedge clk); release_start();
        repeat (10) @(negedge clk);

        // Reset in cycle 4 of a sort aborts it without a done pulse.
        @(negedge clk);
        issue(0, 16'hA3F7);
        e0 = cyc + 1;
        @(negedge clk); release_start();
        while (cyc < e0 + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        chk("abort_busy", b0, 0);
        chk("abort_data", do0, 0);
        chk("abort_swap", sc0, 0);
        repeat (10) @(negedge clk);

        // Randomized
        for (int n = 0; n < 20; n++) run(0, 16'($urandom));
        for (int n = 0; n < 10; n++) run(1, 16'($urandom));
        for (int n = 0; n < 6; n++)  run(2, 16'($urandom_range(0, 255)));

        repeat (4) @(negedge clk);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        chk("pending2", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
